// File: rtl/decode_operand_stage.sv
// MIPS ID stage: decodes the fetched word, drives register-file read addresses and
// captures operands into an ID/EX register with valid/ready flow control.
module decode_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit LOAD_STALL = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [DATA_WIDTH-1:0] if_instr,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] rf_read_reg1,
    output logic [ADDR_WIDTH-1:0] rf_read_reg2,
    input  logic [DATA_WIDTH-1:0] rf_read_data1,
    input  logic [DATA_WIDTH-1:0] rf_read_data2,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_write_reg,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_op1,
    output logic [DATA_WIDTH-1:0] ex_op2,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_rs,
    output logic [ADDR_WIDTH-1:0] ex_rt,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [5:0]            ex_opcode,
    output logic [5:0]            ex_funct,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   ex_pc_q, ex_imm_q;
    logic [DATA_WIDTH-1:0]   ex_op_q [2];
    logic [ADDR_WIDTH-1:0]   ex_rs_q, ex_rt_q, ex_rd_q;
    logic [5:0]              ex_opcode_q, ex_funct_q;
    logic                    ex_mem_read_q, ex_mem_write_q, ex_reg_write_q;

    logic [5:0]              dec_opcode, dec_funct;
    logic [ADDR_WIDTH-1:0]   dec_rs, dec_rt, dec_rd;
    logic [DATA_WIDTH-1:0]   dec_imm;
    logic                    dec_reg_write, dec_mem_read, dec_mem_write;
    logic                    valid_q, adv, hazard, accept;

    logic [ADDR_WIDTH-1:0]   src_idx  [2];
    logic [ADDR_WIDTH-1:0]   held_idx [2];
    logic [DATA_WIDTH-1:0]   rf_data  [2];
    logic [DATA_WIDTH-1:0]   op_d     [2];

    always_comb begin
        dec_opcode    = if_instr[31:26];
        dec_funct     = if_instr[5:0];
        dec_rs        = if_instr[25:21];
        dec_rt        = if_instr[20:16];
        dec_rd        = (dec_opcode == OP_RTYPE) ? if_instr[15:11] : if_instr[20:16];
        if (dec_opcode == OP_ANDI || dec_opcode == OP_ORI)
            dec_imm = {{(DATA_WIDTH-16){1'b0}}, if_instr[15:0]};
        else
            dec_imm = {{(DATA_WIDTH-16){if_instr[15]}}, if_instr[15:0]};
        dec_reg_write = 1'b0;
        case (dec_opcode)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: dec_reg_write = 1'b1;
            OP_SW, OP_BEQ:                                       dec_reg_write = 1'b0;
            default:                                             dec_reg_write = 1'b0;
        endcase
        // Writes to r0 are architecturally discarded, so never flag them.
        if (dec_rd == '0)
            dec_reg_write = 1'b0;
        dec_mem_read  = (dec_opcode == OP_LW);
        dec_mem_write = (dec_opcode == OP_SW);
    end

    assign rf_read_reg1 = dec_rs;
    assign rf_read_reg2 = dec_rt;

    assign valid_q = (state_q == FULL);
    assign adv     = !valid_q || ex_ready;
    assign hazard  = LOAD_STALL && valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                     ((ex_rd_q == dec_rs) || (ex_rd_q == dec_rt));
    assign if_ready = !reset && !flush && adv && !hazard;
    assign accept   = if_valid && if_ready;

    assign src_idx[0]  = dec_rs;
    assign src_idx[1]  = dec_rt;
    assign held_idx[0] = ex_rs_q;
    assign held_idx[1] = ex_rt_q;
    assign rf_data[0]  = rf_read_data1;
    assign rf_data[1]  = rf_read_data2;

    // register_bank returns pre-write data during its write cycle, so both fresh
    // captures and stalled operands take the writeback value on an index match.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic cap_hit, ref_hit;
            assign cap_hit = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == src_idx[gi]);
            assign ref_hit = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == held_idx[gi]);
            always_comb begin
                op_d[gi] = ex_op_q[gi];
                if (accept)
                    op_d[gi] = cap_hit ? wb_write_data : rf_data[gi];
                else if (!adv && ref_hit)
                    op_d[gi] = wb_write_data;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= EMPTY;
            ex_pc_q        <= '0;
            ex_imm_q       <= '0;
            ex_op_q[0]     <= '0;
            ex_op_q[1]     <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_opcode_q    <= '0;
            ex_funct_q     <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            ex_op_q[0] <= op_d[0];
            ex_op_q[1] <= op_d[1];
            if (adv)
                state_q <= accept ? FULL : EMPTY;
            if (accept) begin
                ex_pc_q        <= if_pc;
                ex_imm_q       <= dec_imm;
                ex_rs_q        <= dec_rs;
                ex_rt_q        <= dec_rt;
                ex_rd_q        <= dec_rd;
                ex_opcode_q    <= dec_opcode;
                ex_funct_q     <= dec_funct;
                ex_mem_read_q  <= dec_mem_read;
                ex_mem_write_q <= dec_mem_write;
                ex_reg_write_q <= dec_reg_write;
            end
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_op1       = ex_op_q[0];
    assign ex_op2       = ex_op_q[1];
    assign ex_imm       = ex_imm_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_rd        = ex_rd_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_funct     = ex_funct_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_reg_write = ex_reg_write_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed instruction vectors feed a scoreboard queue;
// a negedge monitor pops and compares each ID/EX transfer.
module tb_decode_operand_stage;

    typedef struct packed {
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  opcode, funct;
        logic        mr, mw, rw;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, flush, if_valid, if_ready;
    logic [31:0] if_instr, if_pc, rf_read_data1, rf_read_data2, wb_write_data;
    logic [4:0]  rf_read_reg1, rf_read_reg2, wb_write_reg;
    logic        wb_reg_write, ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_opcode, ex_funct;
    logic        ex_mem_read, ex_mem_write, ex_reg_write;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    decode_operand_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && ex_valid && ex_ready) begin
            exp_t e, a;
            a = '{pc: ex_pc, op1: ex_op1, op2: ex_op2, imm: ex_imm, rs: ex_rs, rt: ex_rt,
                  rd: ex_rd, opcode: ex_opcode, funct: ex_funct, mr: ex_mem_read,
                  mw: ex_mem_write, rw: ex_reg_write};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_transfer: got pc=%h with empty scoreboard, required none", ex_pc);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL ex_transfer pc=%h: got op1=%h op2=%h imm=%h rs=%0d rt=%0d rd=%0d opc=%h fn=%h mr=%b mw=%b rw=%b; required op1=%h op2=%h imm=%h rs=%0d rt=%0d rd=%0d opc=%h fn=%h mr=%b mw=%b rw=%b",
                             e.pc, a.op1, a.op2, a.imm, a.rs, a.rt, a.rd, a.opcode, a.funct, a.mr, a.mw, a.rw,
                             e.op1, e.op2, e.imm, e.rs, e.rt, e.rd, e.opcode, e.funct, e.mr, e.mw, e.rw);
                end else begin
                    $display("ok  ex_transfer pc=%h op1=%h op2=%h imm=%h rd=%0d rw=%b",
                             a.pc, a.op1, a.op2, a.imm, a.rd, a.rw);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok  %s = %h", name, act);
        end
    endtask

    // Present one instruction until accepted; waits = cycles spent with if_ready low.
    task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rf1, input logic [31:0] rf2,
                         input exp_t e, input bit push, output int waits);
        bit accepted = 1'b0;
        if_instr = instr; if_pc = pc; rf_read_data1 = rf1; rf_read_data2 = rf2; if_valid = 1'b1;
        waits = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (if_ready) begin
                accepted = 1'b1;
                break;
            end
            waits++;
            @(posedge clock); #1;
        end
        if (!accepted) begin
            checks++; errors++;
            $display("FAIL accept_timeout pc=%h: got no acceptance in 20 cycles, required acceptance", pc);
        end else begin
            if (push) sb_q.push_back(e);
            @(posedge clock); #1;
            chk("latency_ex_valid", {31'd0, ex_valid}, 32'd1);
        end
    endtask

    task automatic idle(input int n);
        if_valid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        int w;
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        rf_read_data1 = '0; rf_read_data2 = '0;
        wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0; ex_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_if_ready", {31'd0, if_ready}, 32'd0);
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_op1", ex_op1, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // ADDI r8,r0,-5
        offer(32'h2008FFFB, 32'h100, 32'h0, 32'h11,
              '{32'h100, 32'h0, 32'h11, 32'hFFFFFFFB, 5'd0, 5'd8, 5'd8, 6'h08, 6'h3B, 1'b0, 1'b0, 1'b1}, 1, w);
        // ADD r9,r8,r8 with same-cycle writeback r8=0x1234 over stale rf data
        wb_reg_write = 1'b1; wb_write_reg = 5'd8; wb_write_data = 32'h1234;
        offer(32'h01084820, 32'h104, 32'h7777, 32'h7777,
              '{32'h104, 32'h1234, 32'h1234, 32'h4820, 5'd8, 5'd8, 5'd9, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1}, 1, w);
        wb_reg_write = 1'b0;
        // ANDI r3,r2,0x8001 (zero-extended)
        offer(32'h30438001, 32'h108, 32'hF0F0, 32'h0A0A,
              '{32'h108, 32'hF0F0, 32'h0A0A, 32'h00008001, 5'd2, 5'd3, 5'd3, 6'h0C, 6'h01, 1'b0, 1'b0, 1'b1}, 1, w);
        // ORI r2,r2,0xFFFF (zero-extended)
        offer(32'h3442FFFF, 32'h10C, 32'h1, 32'h2,
              '{32'h10C, 32'h1, 32'h2, 32'h0000FFFF, 5'd2, 5'd2, 5'd2, 6'h0D, 6'h3F, 1'b0, 1'b0, 1'b1}, 1, w);
        // SW r5,-4(r6)
        offer(32'hACC5FFFC, 32'h110, 32'h2000, 32'h55AA,
              '{32'h110, 32'h2000, 32'h55AA, 32'hFFFFFFFC, 5'd6, 5'd5, 5'd5, 6'h2B, 6'h3C, 1'b0, 1'b1, 1'b0}, 1, w);
        // ADDI r0,r1,1 with a writeback to r0 that must not bypass; reg_write forced 0
        wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hDEAD;
        offer(32'h20200001, 32'h114, 32'h3, 32'h0,
              '{32'h114, 32'h3, 32'h0, 32'h1, 5'd1, 5'd0, 5'd0, 6'h08, 6'h01, 1'b0, 1'b0, 1'b0}, 1, w);
        wb_reg_write = 1'b0;
        // BEQ r1,r2,-1
        offer(32'h1022FFFF, 32'h118, 32'h8, 32'h9,
              '{32'h118, 32'h8, 32'h9, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd2, 6'h04, 6'h3F, 1'b0, 1'b0, 1'b0}, 1, w);
        // LW r8,4(r0) then dependent ADD r9,r8,r1: exactly one bubble
        offer(32'h8C080004, 32'h11C, 32'h0, 32'h4444,
              '{32'h11C, 32'h0, 32'h4444, 32'h4, 5'd0, 5'd8, 5'd8, 6'h23, 6'h04, 1'b1, 1'b0, 1'b1}, 1, w);
        offer(32'h01014820, 32'h120, 32'h50, 32'h60,
              '{32'h120, 32'h50, 32'h60, 32'h4820, 5'd8, 5'd1, 5'd9, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1}, 1, w);
        chk("load_use_stall_cycles", w, 32'd1);
        idle(2);

        // Stall with operand refresh: ADD r7,r5,r6 held while wb writes r5
        ex_ready = 1'b0;
        offer(32'h00A63820, 32'h200, 32'h55, 32'h66,
              '{32'h200, 32'hBEEF, 32'h66, 32'h3820, 5'd5, 5'd6, 5'd7, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1}, 1, w);
        if_valid = 1'b0;
        @(posedge clock); #1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hBEEF;
        @(posedge clock); #1;
        wb_reg_write = 1'b0;
        @(negedge clock);
        chk("refresh_ex_op1", ex_op1, 32'hBEEF);
        chk("refresh_ex_op2_held", ex_op2, 32'h66);
        chk("refresh_ex_pc_held", ex_pc, 32'h200);
        @(posedge clock); #1;
        ex_ready = 1'b1;
        idle(2);

        // Flush while FULL with a new instruction offered
        ex_ready = 1'b0;
        offer(32'h00A63820, 32'h300, 32'h1, 32'h2, '0, 0, w);
        if_instr = 32'h01014820; if_pc = 32'h304; if_valid = 1'b1; flush = 1'b1;
        @(negedge clock);
        chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
        @(posedge clock); #1;
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clock);
        chk("flush_not_accepted", {31'd0, ex_valid}, 32'd0);
        @(posedge clock); #1;

        // Reset mid-stream while FULL
        offer(32'h01014820, 32'h400, 32'h99, 32'h2, '0, 0, w);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_if_ready", {31'd0, if_ready}, 32'd0);
        @(posedge clock); #1;
        chk("midreset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midreset_ex_op1", ex_op1, 32'd0);
        chk("midreset_ex_pc", ex_pc, 32'd0);
        reset = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;

        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(posedge clock);
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending transfers, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
